alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the ALU operand/select interface. Accepts one operand command
//  (a, b, cin) over a valid/ready handshake. Drives it to the ALU responder and
//  steps alu_sel through op codes 0..NUM_OPS-1. Captures each out/cout pair and
//  returns it over a valid/ready result stream. Sits between the command source
//  and the ALU, replacing hand-driven sel sequencing.
// PARAMETERS
//  WIDTH    4  operand width; ALU result is WIDTH+1 bits
//  SEL_W    3  width of alu_sel / res_sel
//  NUM_OPS  4  op codes issued per command, 0..NUM_OPS-1; 1 <= NUM_OPS <= 2**SEL_W
//  ALU_LAT  1  cycles alu_sel is held before the result is sampled; must be >= 1
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        synchronous, active-high
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept a command
//  cmd_a      in   WIDTH    operand a
//  cmd_b      in   WIDTH    operand b
//  cmd_cin    in   1        carry in
//  alu_a      out  WIDTH    operand a to ALU (registered)
//  alu_b      out  WIDTH    operand b to ALU (registered)
//  alu_cin    out  1        carry in to ALU (registered)
//  alu_sel    out  SEL_W    op select to ALU (registered)
//  alu_out    in   WIDTH+1  ALU result
//  alu_cout   in   1        ALU carry out
//  res_valid  out  1        result present
//  res_ready  in   1        result consumer ready
//  res_sel    out  SEL_W    op code the result belongs to
//  res_out    out  WIDTH+1  captured alu_out
//  res_cout   out  1        captured alu_cout
//  busy       out  1        command in progress (state != IDLE)
//  done       out  1        one-cycle pulse after the last result handshake
// BEHAVIOUR
//  - Reset, and the cycle after any reset edge: every output is 0, except cmd_ready = 1. State is IDLE.
//  - FSM states:
//    * IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch a/b/cin into alu_a/b/cin,
//      set alu_sel = 0, load lat_cnt = ALU_LAT-1, go to WAIT.
//    * WAIT: alu_* held stable. When lat_cnt == 0, sample alu_out/alu_cout into
//      res_out/res_cout, set res_sel = alu_sel, go to EMIT. Otherwise decrement lat_cnt.
//    * EMIT: res_valid = 1; res_* and alu_* held stable while res_ready = 0.
//      On res_valid & res_ready:
//      · if alu_sel == NUM_OPS-1: go to IDLE and pulse done for 1 cycle.
//      · otherwise: alu_sel += 1, reload lat_cnt, go to WAIT.
//  - cmd_ready = 0 outside IDLE. cmd_valid while busy is ignored; no queueing.
//  - Latency, with the command accepted at edge T0: first res_valid at cycle T0+ALU_LAT+1.
//    Each following op needs ALU_LAT+1 cycles when res_ready is held at 1.
//  - A command can be accepted in the same cycle that done is high, since IDLE is entered.
//  - res_out and res_cout pass through unmodified; the sequencer does no arithmetic.
//  - Reset in any state aborts the command: pending result dropped, no done pulse,
//    no partial res_valid.
//  - alu_sel never exceeds NUM_OPS-1; no wrap-around within a command.
// STRUCTURE
//  - alu_seq_pkg: state enum (IDLE, WAIT, EMIT) and SEL_FIRST = 0.
//  - Sub-module alu_lat_counter: loadable down-counter with a zero flag, width $clog2(ALU_LAT+1).
//  - Top holds the FSM and the operand/result registers.
//  - Elaboration check fails if ALU_LAT < 1 or NUM_OPS > 2**SEL_W.
// TESTING (bench ALU model: combinational, {alu_cout, alu_out} = fixed function of sel, a, b, cin)
//  1. reset high 2 cycles, then low -> all outputs 0, cmd_ready = 1, busy = 0.
//  2. a=5, b=12, cin=0 accepted at T0, res_ready=1 -> res_valid at T2/T4/T6/T8,
//     res_sel = 0/1/2/3, res_out matches the model; done=1 at T9; cmd_ready=1 at T9.
//  3. res_ready=0 for 5 cycles during op 1 -> res_valid stays 1; res_out, res_sel
//     and alu_sel (=1) stay stable; op 2 issues the cycle after the handshake.
//  4. cmd_valid=1 with new operands while busy -> cmd_ready=0, alu_a/alu_b unchanged,
//     the sequence completes with the original operands.
//  5. reset=1 during EMIT of op 2 -> next cycle all outputs 0, cmd_ready=1, done never pulses.
//  6. ALU_LAT=3 build, same command as test 2 -> res_valid at T4/T8/T12/T16, done at T17.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer.
//   ST_IDLE / ST_WAIT / ST_EMIT : sequencer state encodings
//   state_t                     : state register type
//   SEL_FIRST                   : first op code issued for each command
package alu_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_EMIT = 2'd2;

  localparam int SEL_FIRST = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the command source, the sequencer, the ALU and the
// result consumer.
//   cmd_* : operand command stream (valid/ready) into the sequencer
//   alu_* : registered operands and op select out, combinational result back
//   res_* : captured result stream (valid/ready) out of the sequencer
// Modports:
//   master : sequencer side
//   slave  : environment side (command source, ALU, result consumer)
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH:0]   alu_out;
  logic             alu_cout;

  logic             res_valid;
  logic             res_ready;
  logic [SEL_W-1:0] res_sel;
  logic [WIDTH:0]   res_out;
  logic             res_cout;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_cin,
    output cmd_ready,
    output alu_a, alu_b, alu_cin, alu_sel,
    input  alu_out, alu_cout,
    output res_valid, res_sel, res_out, res_cout,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_cin,
    input  cmd_ready,
    input  alu_a, alu_b, alu_cin, alu_sel,
    output alu_out, alu_cout,
    input  res_valid, res_sel, res_out, res_cout,
    output res_ready
  );

endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter used to time how long alu_sel is held before the
// ALU result is sampled.
//   clk      : clock
//   reset    : synchronous, active-high; clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   zero     : count is zero
module alu_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the ALU operand/select interface. Takes one (a, b, cin)
// command, drives it to the ALU, steps alu_sel through 0..NUM_OPS-1 and
// returns each captured out/cout pair on the result stream.
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : cmd_*, alu_*, res_* signals (sequencer side)
//   busy  : a command is in progress
//   done  : one-cycle pulse after the last result handshake
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a command; alu_* hold the last command
// ST_WAIT | alu_* stable, counting ALU_LAT cycles before sampling result
// ST_EMIT | res_valid high, holding result until res_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SEL_W   = 3,
  parameter int NUM_OPS = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.master  bus,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OPS - 1);

  generate
    if (ALU_LAT < 1 || NUM_OPS < 1 || NUM_OPS > 2**SEL_W) begin : g_bad_cfg
      $error("alu_op_sequencer: need ALU_LAT >= 1 and 1 <= NUM_OPS <= 2**SEL_W");
    end
  endgenerate

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic             cin_q,      cin_d;
  logic [SEL_W-1:0] sel_q,      sel_d;
  logic [WIDTH:0]   res_out_q,  res_out_d;
  logic             res_cout_q, res_cout_d;
  logic [SEL_W-1:0] res_sel_q,  res_sel_d;
  logic             done_q,     done_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  alu_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sel_d      = sel_q;
    res_out_d  = res_out_q;
    res_cout_d = res_cout_q;
    res_sel_d  = res_sel_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          a_d      = bus.cmd_a;
          b_d      = bus.cmd_b;
          cin_d    = bus.cmd_cin;
          sel_d    = SEL_W'(SEL_FIRST);
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          res_out_d  = bus.alu_out;
          res_cout_d = bus.alu_cout;
          res_sel_d  = sel_q;
          state_d    = ST_EMIT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.res_ready) begin
          if (sel_q == SEL_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Next op reuses the latched operands; only the select moves.
            sel_d    = sel_q + SEL_W'(1);
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sel_q      <= '0;
      res_out_q  <= '0;
      res_cout_q <= 1'b0;
      res_sel_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sel_q      <= sel_d;
      res_out_q  <= res_out_d;
      res_cout_q <= res_cout_d;
      res_sel_q  <= res_sel_d;
      done_q     <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_cin   = cin_q;
  assign bus.alu_sel   = sel_q;
  assign bus.res_valid = (state_q == ST_EMIT);
  assign bus.res_sel   = res_sel_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_cout  = res_cout_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule
